// File: rtl/prog_sequencer.sv
// Run controller for ProgCtr: start/halt handshake, branch resolution via a target LUT, squash after taken branches.
// Optional return stack (Call/Ret/PcNow/StackErr) is compiled in when RET_STACK_EN is defined.
module prog_sequencer #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             BranchIsRel,
    input  logic             BranchCond,
    input  logic             ALU_flag,
    input  logic [IDX_W-1:0] TargetIdx,
    input  logic             CfgWe,
    input  logic [IDX_W-1:0] CfgAddr,
    input  logic [PC_W-1:0]  CfgData,
`ifdef RET_STACK_EN
    input  logic             Call,
    input  logic             Ret,
    input  logic [PC_W-1:0]  PcNow,
    output logic             StackErr,
`endif
    output logic             PcStart,
    output logic             BranchAbs,
    output logic             BranchRel,
    output logic             Decision,
    output logic [PC_W-1:0]  Target,
    output logic             InstrKill,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic            restart;

`ifdef RET_STACK_EN
    logic [PC_W-1:0] stack [4];
    logic [2:0]      sp;
    logic [1:0]      top_idx;
    logic            push, pop, err_set, err_q;

    assign top_idx  = sp[1:0] - 2'd1;
    assign StackErr = err_q;
`endif

    // Unreset storage; combinational read sees pre-write contents on a same-address write.
    always_ff @(posedge Clk) begin
        if (CfgWe) lut[CfgAddr] <= CfgData;
    end

    always_comb begin
        PcStart   = 1'b0;
        BranchAbs = 1'b0;
        BranchRel = 1'b0;
        Decision  = 1'b0;
        InstrKill = 1'b0;
        Done      = 1'b0;
        Target    = lut[TargetIdx];
        restart   = 1'b0;
`ifdef RET_STACK_EN
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                PcStart = 1'b1;
                Target  = '0;
                restart = Start;
            end
            RUN: begin
                if (!Halt) begin
`ifdef RET_STACK_EN
                    // Ret has priority over Call, Call over a plain branch; stack faults suppress the branch.
                    if (Ret) begin
                        if (sp == 3'd0) err_set = 1'b1;
                        else begin
                            pop       = 1'b1;
                            BranchAbs = 1'b1;
                            Decision  = 1'b1;
                            Target    = stack[top_idx];
                        end
                    end else if (Call) begin
                        if (sp == 3'd4) err_set = 1'b1;
                        else begin
                            push      = 1'b1;
                            BranchAbs = ~BranchIsRel;
                            BranchRel = BranchIsRel;
                            Decision  = 1'b1;
                        end
                    end else
`endif
                    begin
                        BranchAbs = BranchEn & ~BranchIsRel;
                        BranchRel = BranchEn & BranchIsRel;
                        Decision  = BranchEn & (~BranchCond | ALU_flag);
                    end
                end
            end
            FLUSH: InstrKill = 1'b1;
            HALT: begin
                Done    = 1'b1;
                PcStart = Start;
                restart = Start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            CycleCount <= '0;
        end else begin
            if (restart) begin
                state      <= RUN;
                CycleCount <= '0;
            end else if (state == RUN || state == FLUSH) begin
                if (CycleCount != '1) CycleCount <= CycleCount + CNT_W'(1);
                if (state == FLUSH)   state <= RUN;
                else if (Halt)        state <= HALT;
                else if (Decision)    state <= FLUSH;
            end
        end
    end

`ifdef RET_STACK_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (restart) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (push)    sp    <= sp + 3'd1;
            if (pop)     sp    <= sp - 3'd1;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) stack[sp[1:0]] <= PcNow + PC_W'(1);
    end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer; CycleCount is narrowed so saturation is reachable quickly.
module tb_prog_sequencer;
    localparam int PW = 10;
    localparam int CW = 6;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0, Halt = 1'b0, BranchEn = 1'b0, BranchIsRel = 1'b0;
    logic          BranchCond = 1'b0, ALU_flag = 1'b0;
    logic [4:0]    TargetIdx = '0;
    logic          CfgWe = 1'b0;
    logic [4:0]    CfgAddr = '0;
    logic [PW-1:0] CfgData = '0;
    logic          PcStart, BranchAbs, BranchRel, Decision, InstrKill, Done;
    logic [PW-1:0] Target;
    logic [CW-1:0] CycleCount;
`ifdef RET_STACK_EN
    logic          Call = 1'b0, Ret = 1'b0, StackErr;
    logic [PW-1:0] PcNow = '0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [21:0] sb [$];
    logic [21:0] got, e;

    prog_sequencer #(.PC_W(PW), .LUT_DEPTH(32), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .BranchEn(BranchEn),
        .BranchIsRel(BranchIsRel), .BranchCond(BranchCond), .ALU_flag(ALU_flag),
        .TargetIdx(TargetIdx), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
`ifdef RET_STACK_EN
        .Call(Call), .Ret(Ret), .PcNow(PcNow), .StackErr(StackErr),
`endif
        .PcStart(PcStart), .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Decision(Decision),
        .Target(Target), .InstrKill(InstrKill), .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    assign got = {PcStart, BranchAbs, BranchRel, Decision, InstrKill, Done, Target, CycleCount};

    // ctl = {PcStart, BranchAbs, BranchRel, Decision, InstrKill, Done}
    function automatic logic [21:0] E(input logic [5:0] ctl, input logic [PW-1:0] tgt, input int cnt);
        return {ctl, tgt, CW'(cnt)};
    endfunction

    function automatic logic [10:0] S(input logic st, h, be, rel, cond, fl, input logic [4:0] idx);
        return {st, h, be, rel, cond, fl, idx};
    endfunction

    task automatic drive(input logic [10:0] s);
        {Start, Halt, BranchEn, BranchIsRel, BranchCond, ALU_flag, TargetIdx} = s;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        drive('0);
        CfgWe = 1'b0;
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [PW-1:0] d);
        @(negedge Clk);
        CfgWe = 1'b1; CfgAddr = a; CfgData = d;
        @(negedge Clk);
        CfgWe = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge Clk);
            if (i == 3) Reset = 1'b1;
            drive(S(i < 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'(i)));
            sb.push_back(E(6'b100000, '0, 0));
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_abs_branch();
        logic [10:0] st [6];
        logic [21:0] ex [6];
        do_reset();
        cfg_write(5'd3, 10'd20);
        st = '{S(1,0,0,0,0,0,3), S(0,0,0,0,0,0,3), S(0,0,1,0,0,0,3),
               S(0,1,1,1,0,1,3), S(1,0,0,0,0,0,3), S(0,0,0,0,0,0,3)};
        ex = '{E(6'b100000, 0, 0), E(6'b000000, 20, 0), E(6'b010100, 20, 1),
               E(6'b000010, 20, 2), E(6'b000000, 20, 3), E(6'b000000, 20, 4)};
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            drive(st[i]);
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL abs_branch[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_rel_branch();
        logic [10:0] st [6];
        logic [21:0] ex [6];
        do_reset();
        cfg_write(5'd5, 10'h111);
        st = '{S(1,0,0,0,0,0,5), S(0,0,0,0,0,0,5), S(0,0,1,1,1,0,5),
               S(0,0,1,1,1,1,5), S(0,0,0,0,0,0,5), S(0,0,0,0,0,0,5)};
        ex = '{E(6'b100000, 0, 0), E(6'b000000, 10'h111, 0), E(6'b001000, 10'h3FE, 1),
               E(6'b001100, 10'h3FE, 2), E(6'b000010, 10'h3FE, 3), E(6'b000000, 10'h3FE, 4)};
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            drive(st[i]);
            CfgWe = (i == 1); CfgAddr = 5'd5; CfgData = 10'h3FE;
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rel_branch[%0d] got %h exp %h", i, got, e);
            end
        end
        CfgWe = 1'b0;
    endtask

    task automatic test_halt();
        logic [10:0] st [8];
        logic [21:0] ex [8];
        do_reset();
        cfg_write(5'd7, 10'h155);
        st = '{S(1,0,0,0,0,0,7), S(0,0,0,0,0,0,7), S(0,1,1,0,0,0,7), S(0,0,1,1,1,1,7),
               S(0,1,1,0,0,0,7), S(1,0,0,0,0,0,7), S(0,0,0,0,0,0,7), S(0,0,0,0,0,0,7)};
        ex = '{E(6'b100000, 0, 0), E(6'b000000, 10'h155, 0), E(6'b000000, 10'h155, 1),
               E(6'b000001, 10'h155, 2), E(6'b000001, 10'h155, 2), E(6'b100001, 10'h155, 2),
               E(6'b000000, 10'h155, 0), E(6'b000000, 10'h155, 1)};
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            drive(st[i]);
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL halt[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] st [8];
        logic [21:0] ex [8];
        do_reset();
        cfg_write(5'd4, 10'd33);
        st = '{S(1,0,0,0,0,0,4), S(0,0,1,0,0,0,4), S(0,0,1,0,0,0,4), S(0,0,1,0,0,0,4),
               S(0,0,1,1,0,0,4), S(0,0,1,1,0,0,4), S(0,0,0,0,0,0,4), S(0,0,0,0,0,0,4)};
        ex = '{E(6'b100000, 0, 0), E(6'b010100, 33, 0), E(6'b000010, 33, 1), E(6'b010100, 33, 2),
               E(6'b000010, 33, 3), E(6'b001100, 33, 4), E(6'b000010, 33, 5), E(6'b000000, 33, 6)};
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            drive(st[i]);
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got %h exp %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_in_flush();
        logic [10:0] st [3];
        logic [21:0] ex [3];
        do_reset();
        cfg_write(5'd2, 10'd9);
        st = '{S(1,0,0,0,0,0,2), S(0,0,1,0,0,0,2), S(0,0,0,0,0,0,2)};
        ex = '{E(6'b100000, 0, 0), E(6'b010100, 9, 0), E(6'b000010, 9, 1)};
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            drive(st[i]);
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_in_flush[%0d] got %h exp %h", i, got, e);
            end
        end
        #1 Reset = 1'b0;
        sb.push_back(E(6'b100000, 0, 0));
        #1 e = sb.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_in_flush_async got %h exp %h", got, e);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_saturate();
        do_reset();
        cfg_write(5'd3, 10'd20);
        @(negedge Clk);
        drive(S(1,0,0,0,0,0,3));
        for (int i = 0; i < 70; i++) begin
            @(negedge Clk);
            drive(S(0,0,0,0,0,0,3));
            if (i == 62 || i == 63 || i == 69) begin
                sb.push_back(E(6'b000000, 20, (i > 63) ? 63 : i));
                #1 e = sb.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL saturate[%0d] got %h exp %h", i, got, e);
                end
            end
        end
    endtask

`ifdef RET_STACK_EN
    task automatic test_stack();
        // row fields: {Call, Ret, PcNow}
        logic [11:0] sk [14];
        logic [21:0] ex [14];
        logic        xe [14];
        do_reset();
        cfg_write(5'd1, 10'd50);
        sk = '{{2'b00, 10'd0},  {2'b10, 10'd10}, {2'b10, 10'd0}, {2'b10, 10'd11}, {2'b10, 10'd0},
               {2'b10, 10'd12}, {2'b10, 10'd0},  {2'b10, 10'd13}, {2'b01, 10'd0}, {2'b10, 10'd14},
               {2'b01, 10'd0},  {2'b00, 10'd0},  {2'b00, 10'd0},  {2'b00, 10'd0}};
        ex = '{E(6'b100000, 0, 0),  E(6'b010100, 50, 0), E(6'b000010, 50, 1), E(6'b010100, 50, 2),
               E(6'b000010, 50, 3), E(6'b010100, 50, 4), E(6'b000010, 50, 5), E(6'b010100, 50, 6),
               E(6'b000010, 50, 7), E(6'b000000, 50, 8), E(6'b010100, 14, 9), E(6'b000010, 50, 10),
               E(6'b000000, 50, 11), E(6'b000000, 50, 12)};
        xe = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        // Rows 1..9: four good pushes then a fifth on a full stack; row 8 Ret sits in FLUSH and is ignored.
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            drive(S(i == 0, 0, 0, 0, 0, 0, 1));
            {Call, Ret, PcNow} = sk[i];
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e || StackErr !== xe[i]) begin
                n_fail++;
                $display("FAIL stack_full[%0d] got %h err %b exp %h err %b", i, got, StackErr, e, xe[i]);
            end
        end
        // Restart clears the stack and error; Call at 7 then Ret returns to 8; Ret on empty faults.
        sk = '{{2'b00, 10'd0}, {2'b10, 10'd7}, {2'b00, 10'd0}, {2'b01, 10'd0}, {2'b00, 10'd0},
               {2'b01, 10'd0}, {2'b00, 10'd0}, {2'b00, 10'd0}, {2'b00, 10'd0}, {2'b00, 10'd0},
               {2'b00, 10'd0}, {2'b00, 10'd0}, {2'b00, 10'd0}, {2'b00, 10'd0}};
        ex[0:6] = '{E(6'b100000, 0, 0), E(6'b010100, 50, 0), E(6'b000010, 50, 1), E(6'b010100, 8, 2),
                    E(6'b000010, 50, 3), E(6'b000000, 50, 4), E(6'b000000, 50, 5)};
        xe[0:6] = '{0, 0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            drive(S(i == 0, 0, 0, 0, 0, 0, 1));
            {Call, Ret, PcNow} = sk[i];
            sb.push_back(ex[i]);
            #1 e = sb.pop_front();
            n_cmp++;
            if (got !== e || StackErr !== xe[i]) begin
                n_fail++;
                $display("FAIL stack_ret[%0d] got %h err %b exp %h err %b", i, got, StackErr, e, xe[i]);
            end
        end
        {Call, Ret} = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_abs_branch();
        test_rel_branch();
        test_halt();
        test_back_to_back();
        test_reset_in_flush();
        test_saturate();
`ifdef RET_STACK_EN
        test_stack();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
